hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Parametrised pipeline hazard controller for the 5-stage MIPS core. It generates forwarding selects, per-stage stall and flush signals, and the pipeline freeze for a multi-cycle divider. It also handles instruction- and data-memory wait states and defers exception flushes that arrive during a data-memory stall. It sits beside the datapath and is driven purely by the stage register fields.

## Interface
Parameters:
- REG_AW, 5, register-number width
- DIV_CYCLES, 32, divider busy cycles (≥1)
- FWD_EN, 1, 1 = forwarding enabled; 0 = every RAW hazard resolved by stalling D

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rsD, rtD  in  REG_AW  D-stage source registers
- branchD, jrD  in  1  D-stage branch / jr-jalr
- rsE, rtE, writeregE  in  REG_AW  E-stage fields
- regwriteE, memtoregE, divstartE  in  1  E-stage controls (divstartE = div/divu in E)
- writeregM  in  REG_AW; regwriteM, memtoregM, exceptM  in  1  M-stage fields
- writeregW  in  REG_AW; regwriteW  in  1  W-stage fields
- i_stall, d_stall  in  1  instruction/data memory not ready
- forwardaD, forwardbD  out  1  D-stage compare operand from M
- forwardaE, forwardbE  out  2  10 = M, 01 = W, 00 = regfile
- stallF, stallD, stallE, stallM  out  1  hold stage register
- flushD, flushE, flushM, flushW  out  1  insert bubble into stage register
- div_busy  out  1  divider FSM not IDLE

## Operation
- Register 0 never matches in any comparison.
- Forwarding (FWD_EN=1):
  - forwardaE = 10 if rsE==writeregM & regwriteM; else 01 if rsE==writeregW & regwriteW; else 00. forwardbE uses rtE the same way.
  - forwardaD/forwardbD = rsD/rtD == writeregM & regwriteM.
  - FWD_EN=0: all forward outputs are 0.
- D-level stall (dstall), as the OR of:
  - lw: memtoregE & regwriteE & writeregE∈{rsD, rtD}.
  - branch: branchD & ((regwriteE & writeregE∈{rsD, rtD}) | (memtoregM & writeregM∈{rsD, rtD})).
  - jr: jrD, same terms as branch, rsD only.
  - FWD_EN=0 only: regwrite of E, M or W with writereg∈{rsD, rtD}.
- Divider FSM states IDLE, BUSY, DONE; cnt is a $clog2(DIV_CYCLES+1)-bit counter.
  - IDLE & divstartE: go to BUSY, cnt ← DIV_CYCLES−1.
  - BUSY: cnt decrements each cycle; at cnt==0 go to DONE.
  - DONE: always go to IDLE; divstartE is ignored here because the same div is still in E.
  - divstall = (IDLE & divstartE) | BUSY.
  - div_busy = state≠IDLE.
- Exception pending bit `pend`:
  - Set when exceptM & d_stall.
  - Cleared when the flush is applied.
  - take_exc = (exceptM | pend) & ~d_stall.
- Output priority (highest first, exactly one row applies):
  1. take_exc: flushD=flushE=flushM=1, all stalls 0; FSM → IDLE; pend → 0.
  2. d_stall: stallF=D=E=M=1, flushW=1.
  3. divstall: stallF=D=E=1, flushM=1.
  4. dstall: stallF=D=1, flushE=1.
  5. i_stall: stallF=1, flushD=1.
  6. Otherwise all stalls and flushes are 0.
- Divider FSM advances only when d_stall=0; it holds state during a memory stall.

## Timing
- Forward, stall and flush outputs are combinational from inputs and registered state, valid in the same cycle.
- Reset (rst=1 at a clock edge): state=IDLE, cnt=0, pend=0.
- While rst=1, all stalls are 0, all flushes are 1, and div_busy=0.
- Divider with no memory stall: divstartE seen in cycle t gives stallE=1 for cycles t…t+DIV_CYCLES (DIV_CYCLES+1 cycles). DONE is cycle t+DIV_CYCLES+1; stalls are released and E advances.
- The exception flush is applied in the first cycle with d_stall=0. That is the same cycle if no memory stall, else the cycle d_stall deasserts.
- Reset mid-BUSY aborts the divide; the next cycle starts in IDLE.

## Test plan
- Forwarding: rsE=rtE=3, writeregM=3 & regwriteM, writeregW=3 & regwriteW → forwardaE=forwardbE=10. Drop regwriteM → 01. Set rsE=0 → forwardaE=00.
- Load-use: memtoregE=regwriteE=1, writeregE=5, rtD=5 → stallF=stallD=flushE=1 for one cycle. With rsD=rtD=0 there is no stall.
- Divider (DIV_CYCLES=4): divstartE pulse held while stalled → stallE high exactly 5 cycles, flushM high the same 5 cycles. div_busy is high from the next cycle through DONE, then IDLE. No retrigger.
- d_stall for 3 cycles inside a divide → FSM holds, total divider stall extended by 3 cycles, flushW=1 only during d_stall.
- exceptM during d_stall: flushD/E/M stay 0 while d_stall=1, assert for one cycle when it drops, and pend clears. exceptM mid-BUSY → FSM to IDLE the next cycle.
- FWD_EN=0: regwriteW=1, writeregW=7, rsD=7 → stallD=1, forward outputs 0. rst=1 mid-BUSY → div_busy=0 the next cycle.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage MIPS core: forwarding selects,
// per-stage stall/flush, divider freeze, memory wait states and deferred exceptions.
module hazard_ctrl #(
  parameter int REG_AW     = 5,
  parameter int DIV_CYCLES = 32,
  parameter bit FWD_EN     = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rsD,
  input  logic [REG_AW-1:0] rtD,
  input  logic              branchD,
  input  logic              jrD,
  input  logic [REG_AW-1:0] rsE,
  input  logic [REG_AW-1:0] rtE,
  input  logic [REG_AW-1:0] writeregE,
  input  logic              regwriteE,
  input  logic              memtoregE,
  input  logic              divstartE,
  input  logic [REG_AW-1:0] writeregM,
  input  logic              regwriteM,
  input  logic              memtoregM,
  input  logic              exceptM,
  input  logic [REG_AW-1:0] writeregW,
  input  logic              regwriteW,
  input  logic              i_stall,
  input  logic              d_stall,
  output logic              forwardaD,
  output logic              forwardbD,
  output logic [1:0]        forwardaE,
  output logic [1:0]        forwardbE,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              stallM,
  output logic              flushD,
  output logic              flushE,
  output logic              flushM,
  output logic              flushW,
  output logic              div_busy
);

  localparam int CW = $clog2(DIV_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} divState_t;

  divState_t     state, stateNext;
  logic [CW-1:0] cnt, cntNext;
  logic          pend, pendNext;
  logic          takeExc, divStall, dStall;
  logic          lwHaz, branchHaz, jrHaz, noFwdHaz;

  // Register 0 is hard-wired, so a zero register number never matches.
  function automatic logic hit(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  always_comb begin
    forwardaE = 2'b00;
    forwardbE = 2'b00;
    forwardaD = 1'b0;
    forwardbD = 1'b0;
    if (FWD_EN) begin
      if (regwriteM && hit(rsE, writeregM))      forwardaE = 2'b10;
      else if (regwriteW && hit(rsE, writeregW)) forwardaE = 2'b01;
      if (regwriteM && hit(rtE, writeregM))      forwardbE = 2'b10;
      else if (regwriteW && hit(rtE, writeregW)) forwardbE = 2'b01;
      forwardaD = regwriteM && hit(rsD, writeregM);
      forwardbD = regwriteM && hit(rtD, writeregM);
    end
  end

  always_comb begin
    lwHaz     = memtoregE && regwriteE && (hit(rsD, writeregE) || hit(rtD, writeregE));
    branchHaz = branchD && ((regwriteE && (hit(rsD, writeregE) || hit(rtD, writeregE))) ||
                            (memtoregM && (hit(rsD, writeregM) || hit(rtD, writeregM))));
    jrHaz     = jrD && ((regwriteE && hit(rsD, writeregE)) || (memtoregM && hit(rsD, writeregM)));
    noFwdHaz  = 1'b0;
    if (!FWD_EN)
      noFwdHaz = (regwriteE && (hit(rsD, writeregE) || hit(rtD, writeregE))) ||
                 (regwriteM && (hit(rsD, writeregM) || hit(rtD, writeregM))) ||
                 (regwriteW && (hit(rsD, writeregW) || hit(rtD, writeregW)));
    dStall    = lwHaz || branchHaz || jrHaz || noFwdHaz;
    divStall  = ((state == IDLE) && divstartE) || (state == BUSY);
    takeExc   = (exceptM || pend) && !d_stall;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      pend  <= 1'b0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      pend  <= pendNext;
    end
  end

  // The divider freezes during a data-memory stall; an exception aborts it.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    pendNext  = pend;
    if (takeExc) begin
      stateNext = IDLE;
      cntNext   = '0;
      pendNext  = 1'b0;
    end else if (d_stall) begin
      if (exceptM) pendNext = 1'b1;
    end else begin
      unique case (state)
        IDLE: if (divstartE) begin
          stateNext = BUSY;
          cntNext   = CW'(DIV_CYCLES - 1);
        end
        BUSY: if (cnt == '0) stateNext = DONE;
              else           cntNext   = cnt - CW'(1);
        DONE:    stateNext = IDLE;
        default: stateNext = IDLE;
      endcase
    end
  end

  always_comb begin
    stallF = 1'b0; stallD = 1'b0; stallE = 1'b0; stallM = 1'b0;
    flushD = 1'b0; flushE = 1'b0; flushM = 1'b0; flushW = 1'b0;
    div_busy = (state != IDLE) && !rst;
    if (rst) begin
      flushD = 1'b1; flushE = 1'b1; flushM = 1'b1; flushW = 1'b1;
    end else if (takeExc) begin
      flushD = 1'b1; flushE = 1'b1; flushM = 1'b1;
    end else if (d_stall) begin
      stallF = 1'b1; stallD = 1'b1; stallE = 1'b1; stallM = 1'b1;
      flushW = 1'b1;
    end else if (divStall) begin
      stallF = 1'b1; stallD = 1'b1; stallE = 1'b1;
      flushM = 1'b1;
    end else if (dStall) begin
      stallF = 1'b1; stallD = 1'b1;
      flushE = 1'b1;
    end else if (i_stall) begin
      stallF = 1'b1;
      flushD = 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl: one instance with forwarding, one without,
// sharing inputs; expected outputs queued per cycle and checked by a monitor.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic branchD, jrD, regwriteE, memtoregE, divstartE;
  logic regwriteM, memtoregM, exceptM, regwriteW, i_stall, d_stall;

  logic       faD0, fbD0, faD1, fbD1;
  logic [1:0] faE0, fbE0, faE1, fbE1;
  logic       sF0, sD0, sE0, sM0, fD0, fE0, fM0, fW0, busy0;
  logic       sF1, sD1, sE1, sM1, fD1, fE1, fM1, fW1, busy1;
  logic [14:0] out0, out1;

  logic [15:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_AW(5), .DIV_CYCLES(4), .FWD_EN(1'b1)) u0 (
    .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .branchD(branchD), .jrD(jrD),
    .rsE(rsE), .rtE(rtE), .writeregE(writeregE), .regwriteE(regwriteE),
    .memtoregE(memtoregE), .divstartE(divstartE), .writeregM(writeregM),
    .regwriteM(regwriteM), .memtoregM(memtoregM), .exceptM(exceptM),
    .writeregW(writeregW), .regwriteW(regwriteW), .i_stall(i_stall), .d_stall(d_stall),
    .forwardaD(faD0), .forwardbD(fbD0), .forwardaE(faE0), .forwardbE(fbE0),
    .stallF(sF0), .stallD(sD0), .stallE(sE0), .stallM(sM0),
    .flushD(fD0), .flushE(fE0), .flushM(fM0), .flushW(fW0), .div_busy(busy0)
  );

  hazard_ctrl #(.REG_AW(5), .DIV_CYCLES(4), .FWD_EN(1'b0)) u1 (
    .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .branchD(branchD), .jrD(jrD),
    .rsE(rsE), .rtE(rtE), .writeregE(writeregE), .regwriteE(regwriteE),
    .memtoregE(memtoregE), .divstartE(divstartE), .writeregM(writeregM),
    .regwriteM(regwriteM), .memtoregM(memtoregM), .exceptM(exceptM),
    .writeregW(writeregW), .regwriteW(regwriteW), .i_stall(i_stall), .d_stall(d_stall),
    .forwardaD(faD1), .forwardbD(fbD1), .forwardaE(faE1), .forwardbE(fbE1),
    .stallF(sF1), .stallD(sD1), .stallE(sE1), .stallM(sM1),
    .flushD(fD1), .flushE(fE1), .flushM(fM1), .flushW(fW1), .div_busy(busy1)
  );

  assign out0 = {faD0, fbD0, faE0, fbE0, sF0, sD0, sE0, sM0, fD0, fE0, fM0, fW0, busy0};
  assign out1 = {faD1, fbD1, faE1, fbE1, sF1, sD1, sE1, sM1, fD1, fE1, fM1, fW1, busy1};

  // stl = {stallF, stallD, stallE, stallM}; fl = {flushD, flushE, flushM, flushW}
  function automatic logic [14:0] mk(input logic fad, input logic fbd, input logic [1:0] fae,
                                     input logic [1:0] fbe, input logic [3:0] stl,
                                     input logic [3:0] fl, input logic busy);
    return {fad, fbd, fae, fbe, stl, fl, busy};
  endfunction

  localparam logic [14:0] ZERO = 15'd0;

  task automatic clr();
    rsD = 0; rtD = 0; rsE = 0; rtE = 0; writeregE = 0; writeregM = 0; writeregW = 0;
    branchD = 0; jrD = 0; regwriteE = 0; memtoregE = 0; divstartE = 0;
    regwriteM = 0; memtoregM = 0; exceptM = 0; regwriteW = 0; i_stall = 0; d_stall = 0;
  endtask

  // Queue the expectation for the current inputs, then advance one cycle.
  task automatic cyc(input logic sel, input logic [14:0] e, input string nm);
    exp_q.push_back({sel, e});
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [15:0] e;
      logic [14:0] act;
      string nm;
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      act = e[15] ? out1 : out0;
      checks++;
      if (act !== e[14:0]) begin
        errors++;
        $display("FAIL %s (dut%0d): got %b expected %b", nm, e[15], act, e[14:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    clr();
    @(posedge clk);
    #1;
    cyc(0, mk(0, 0, 2'b00, 2'b00, 4'b0000, 4'b1111, 0), "reset_u0");
    cyc(1, mk(0, 0, 2'b00, 2'b00, 4'b0000, 4'b1111, 0), "reset_u1");
    rst = 1'b0;
    cyc(0, ZERO, "idle");

    rsE = 3; rtE = 3; writeregM = 3; regwriteM = 1; writeregW = 3; regwriteW = 1;
    cyc(0, mk(0, 0, 2'b10, 2'b10, 4'b0000, 4'b0000, 0), "fwdE_from_M");
    cyc(1, ZERO, "fwdE_disabled");
    regwriteM = 0;
    cyc(0, mk(0, 0, 2'b01, 2'b01, 4'b0000, 4'b0000, 0), "fwdE_from_W");
    rsE = 0;
    cyc(0, mk(0, 0, 2'b00, 2'b01, 4'b0000, 4'b0000, 0), "fwdE_reg0");

    clr(); rsD = 4; writeregM = 4; regwriteM = 1;
    cyc(0, mk(1, 0, 2'b00, 2'b00, 4'b0000, 4'b0000, 0), "fwdD_from_M");
    cyc(1, mk(0, 0, 2'b00, 2'b00, 4'b1100, 4'b0100, 0), "nofwd_M_stall");

    clr(); memtoregE = 1; regwriteE = 1; writeregE = 5; rtD = 5;
    cyc(0, mk(0, 0, 2'b00, 2'b00, 4'b1100, 4'b0100, 0), "load_use");
    rtD = 0;
    cyc(0, ZERO, "load_use_none");

    clr(); branchD = 1; rsD = 6; memtoregM = 1; writeregM = 6;
    cyc(0, mk(0, 0, 2'b00, 2'b00, 4'b1100, 4'b0100, 0), "branch_load_M");
    clr(); jrD = 1; rsD = 2; rtD = 6; regwriteE = 1; writeregE = 6;
    cyc(0, ZERO, "jr_ignores_rt");
    rsD = 6;
    cyc(0, mk(0, 0, 2'b00, 2'b00, 4'b1100, 4'b0100, 0), "jr_rs_E");

    clr(); i_stall = 1;
    cyc(0, mk(0, 0, 2'b00, 2'b00, 4'b1000, 4'b1000, 0), "i_stall");

    clr(); regwriteW = 1; writeregW = 7; rsD = 7;
    cyc(1, mk(0, 0, 2'b00, 2'b00, 4'b1100, 4'b0100, 0), "nofwd_W_stall");
    cyc(0, ZERO, "fwd_W_no_stall");

    clr(); regwriteM = 1; regwriteE = 1; memtoregE = 1; regwriteW = 1;
    cyc(0, ZERO, "reg0_u0");
    cyc(1, ZERO, "reg0_u1");

    // Divider, DIV_CYCLES=4: five stall cycles, then DONE, then IDLE.
    clr(); divstartE = 1;
    for (int i = 0; i < 5; i++)
      cyc(0, mk(0, 0, 2'b00, 2'b00, 4'b1110, 4'b0010, (i != 0)), "div_stall");
    cyc(0, mk(0, 0, 2'b00, 2'b00, 4'b0000, 4'b0000, 1), "div_done");
    divstartE = 0;
    cyc(0, ZERO, "div_idle");

    // Divider extended by a 3-cycle data-memory stall.
    divstartE = 1;
    for (int i = 0; i < 2; i++)
      cyc(0, mk(0, 0, 2'b00, 2'b00, 4'b1110, 4'b0010, (i != 0)), "div_pre_dstall");
    d_stall = 1;
    for (int i = 0; i < 3; i++)
      cyc(0, mk(0, 0, 2'b00, 2'b00, 4'b1111, 4'b0001, 1), "div_dstall");
    d_stall = 0;
    for (int i = 0; i < 3; i++)
      cyc(0, mk(0, 0, 2'b00, 2'b00, 4'b1110, 4'b0010, 1), "div_post_dstall");
    cyc(0, mk(0, 0, 2'b00, 2'b00, 4'b0000, 4'b0000, 1), "div_done2");
    divstartE = 0;
    cyc(0, ZERO, "div_idle2");

    // Exception deferred across a data-memory stall.
    clr(); exceptM = 1; d_stall = 1;
    for (int i = 0; i < 2; i++)
      cyc(0, mk(0, 0, 2'b00, 2'b00, 4'b1111, 4'b0001, 0), "exc_deferred");
    exceptM = 0; d_stall = 0;
    cyc(0, mk(0, 0, 2'b00, 2'b00, 4'b0000, 4'b1110, 0), "exc_pending_flush");
    cyc(0, ZERO, "exc_pend_cleared");

    // Exception aborts a running divide.
    clr(); divstartE = 1;
    cyc(0, mk(0, 0, 2'b00, 2'b00, 4'b1110, 4'b0010, 0), "exc_div_start");
    cyc(0, mk(0, 0, 2'b00, 2'b00, 4'b1110, 4'b0010, 1), "exc_div_busy");
    divstartE = 0; exceptM = 1;
    cyc(0, mk(0, 0, 2'b00, 2'b00, 4'b0000, 4'b1110, 1), "exc_mid_busy");
    exceptM = 0;
    cyc(0, ZERO, "exc_div_idle");

    // Reset aborts a running divide.
    divstartE = 1;
    cyc(0, mk(0, 0, 2'b00, 2'b00, 4'b1110, 4'b0010, 0), "rst_div_start");
    cyc(0, mk(0, 0, 2'b00, 2'b00, 4'b1110, 4'b0010, 1), "rst_div_busy");
    divstartE = 0; rst = 1;
    cyc(0, mk(0, 0, 2'b00, 2'b00, 4'b0000, 4'b1111, 0), "rst_mid_busy");
    rst = 0;
    cyc(0, ZERO, "rst_div_idle");

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
